// File: rtl/memgame_pkg.sv
// Shared types and default timing constants for the memory-card game.
package memgame_pkg;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    EXPIRED    = 3'd1,
    PAUSE      = 3'd2,
    PAUSE_DONE = 3'd3,
    FROZEN     = 3'd4
  } timer_state_t;

  localparam int TURN_SECS_DEF  = 15;
  localparam int PAUSE_SECS_DEF = 2;

endpackage

// File: rtl/turn_timer_tick_gen.sv
// One-second prescaler; with TURN_TIMER_WARN_EN it also flags half-second boundaries.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
`ifdef TURN_TIMER_WARN_EN
  output logic half_o,
`endif
  output logic tick_o
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

`ifdef TURN_TIMER_WARN_EN
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2 - 1);
  assign half_o = (cnt_q == HALF) || (cnt_q == LAST);
`endif

endmodule

// File: rtl/turn_timer.sv
// Turn countdown and mismatch-pause timer feeding the game control FSM.
// Optional low-time blink on warn_o is built when TURN_TIMER_WARN_EN is defined.
module turn_timer
  import memgame_pkg::*;
#(
  parameter  int CLK_HZ     = 50_000_000,
  parameter  int TURN_SECS  = TURN_SECS_DEF,
  parameter  int PAUSE_SECS = PAUSE_SECS_DEF,
  parameter  int WARN_SECS  = 5,
  localparam int SW         = $clog2(TURN_SECS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart_i,
  input  logic          extra_turn_i,
  input  logic          end_turn_i,
  input  logic          start_pause_i,
  input  logic          freeze_i,
  output logic          time_up_o,
  output logic          pause_done_o,
  output logic          pause_active_o,
  output logic [SW-1:0] secs_left_o,
  output logic          warn_o,
  output logic [2:0]    state_o
);

  localparam int PW = $clog2(PAUSE_SECS + 1);

  if (CLK_HZ < 2 || TURN_SECS < 1 || PAUSE_SECS < 1 || WARN_SECS < 0) begin : g_bad_params
    $error("turn_timer: illegal parameter combination");
  end

  timer_state_t  state_q, state_d;
  logic [SW-1:0] secs_q, secs_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          time_up_q, time_up_d;
  logic          pdone_q, pdone_d;
  logic          pact_q, pact_d;
  logic          tick_clr, tick;
  logic          reload;

  assign reload = restart_i || extra_turn_i || end_turn_i;

  // Priority: freeze > reload > start_pause > tick.
  always_comb begin
    state_d   = state_q;
    secs_d    = secs_q;
    pcnt_d    = pcnt_q;
    time_up_d = time_up_q;
    pdone_d   = pdone_q;
    pact_d    = pact_q;
    tick_clr  = 1'b0;
    if (state_q == FROZEN) begin
      tick_clr = 1'b1;
    end else if (freeze_i) begin
      state_d   = FROZEN;
      time_up_d = 1'b0;
      pdone_d   = 1'b0;
      pact_d    = 1'b0;
      tick_clr  = 1'b1;
    end else if (reload) begin
      state_d   = RUN;
      secs_d    = SW'(TURN_SECS);
      time_up_d = 1'b0;
      pdone_d   = 1'b0;
      pact_d    = 1'b0;
      tick_clr  = 1'b1;
    end else if (start_pause_i && (state_q == RUN || state_q == EXPIRED)) begin
      state_d   = PAUSE;
      pcnt_d    = PW'(PAUSE_SECS);
      time_up_d = 1'b0;
      pact_d    = 1'b1;
      tick_clr  = 1'b1;
    end else if (tick) begin
      case (state_q)
        RUN: begin
          secs_d = secs_q - 1'b1;
          if (secs_q == SW'(1)) begin
            state_d   = EXPIRED;
            time_up_d = 1'b1;
          end
        end
        PAUSE: begin
          pcnt_d = pcnt_q - 1'b1;
          if (pcnt_q == PW'(1)) begin
            state_d = PAUSE_DONE;
            pdone_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      secs_q    <= SW'(TURN_SECS);
      pcnt_q    <= '0;
      time_up_q <= 1'b0;
      pdone_q   <= 1'b0;
      pact_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      pcnt_q    <= pcnt_d;
      time_up_q <= time_up_d;
      pdone_q   <= pdone_d;
      pact_q    <= pact_d;
    end
  end

`ifdef TURN_TIMER_WARN_EN
  logic half;
  logic warn_q, warn_d;
  logic in_win_q, in_win_d;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tick_clr),
    .half_o (half),
    .tick_o (tick)
  );

  assign in_win_q = (state_q == RUN) && (secs_q != '0) && (int'(secs_q) <= WARN_SECS);
  assign in_win_d = (state_d == RUN) && (secs_d != '0) && (int'(secs_d) <= WARN_SECS);

  // Blink starts high on window entry, then flips on every half-second boundary.
  always_comb begin
    warn_d = 1'b0;
    if (in_win_d) begin
      if (!in_win_q || tick_clr) begin
        warn_d = 1'b1;
      end else if (half) begin
        warn_d = ~warn_q;
      end else begin
        warn_d = warn_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn_o = warn_q;
`else
  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  assign warn_o = 1'b0;
`endif

  assign time_up_o      = time_up_q;
  assign pause_done_o   = pdone_q;
  assign pause_active_o = pact_q;
  assign secs_left_o    = secs_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_turn_timer.sv
// Table-driven scoreboard bench for turn_timer (default build, warn feature off).
module tb_turn_timer;

  localparam int CLK_HZ     = 4;
  localparam int TURN_SECS  = 3;
  localparam int PAUSE_SECS = 2;
  localparam int WARN_SECS  = 2;
  localparam int SW         = $clog2(TURN_SECS + 1);
  localparam int TURN_CYC   = TURN_SECS * CLK_HZ;

  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] RS = 5'b10000;
  localparam logic [4:0] EX = 5'b01000;
  localparam logic [4:0] ET = 5'b00100;
  localparam logic [4:0] SP = 5'b00010;
  localparam logic [4:0] FZ = 5'b00001;

  localparam int S_RUN = 0, S_EXP = 1, S_PAU = 2, S_PDN = 3, S_FRZ = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart_i = 1'b0, extra_turn_i = 1'b0, end_turn_i = 1'b0;
  logic          start_pause_i = 1'b0, freeze_i = 1'b0;
  logic          time_up_o, pause_done_o, pause_active_o, warn_o;
  logic [SW-1:0] secs_left_o;
  logic [2:0]    state_o;

  turn_timer #(
    .CLK_HZ(CLK_HZ), .TURN_SECS(TURN_SECS), .PAUSE_SECS(PAUSE_SECS), .WARN_SECS(WARN_SECS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .restart_i(restart_i), .extra_turn_i(extra_turn_i), .end_turn_i(end_turn_i),
    .start_pause_i(start_pause_i), .freeze_i(freeze_i),
    .time_up_o(time_up_o), .pause_done_o(pause_done_o), .pause_active_o(pause_active_o),
    .secs_left_o(secs_left_o), .warn_o(warn_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] inp;
    logic       tu;
    logic       pd;
    logic       pa;
    int         secs;
    int         st;
    string      nm;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [4:0] inp, input logic tu, input logic pd,
                              input logic pa, input int secs, input int st, input string nm);
    vec_t v;
    v.inp = inp; v.tu = tu; v.pd = pd; v.pa = pa; v.secs = secs; v.st = st; v.nm = nm;
    return v;
  endfunction

  // Expected outputs j cycles after a reload with no further strobes.
  function automatic vec_t run_exp(input int j, input string nm);
    if (j >= TURN_CYC) return mk(NO, 1'b1, 1'b0, 1'b0, 0, S_EXP, nm);
    return mk(NO, 1'b0, 1'b0, 1'b0, TURN_SECS - j / CLK_HZ, S_RUN, nm);
  endfunction

  task automatic check_out();
    vec_t e;
    e = sbq.pop_front();
    n_vec++;
    if (time_up_o !== e.tu || pause_done_o !== e.pd || pause_active_o !== e.pa ||
        int'(secs_left_o) != e.secs || int'(state_o) != e.st || warn_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got tu=%0b pd=%0b pa=%0b secs=%0d st=%0d warn=%0b, want tu=%0b pd=%0b pa=%0b secs=%0d st=%0d warn=0",
               e.nm, time_up_o, pause_done_o, pause_active_o, secs_left_o, state_o, warn_o,
               e.tu, e.pd, e.pa, e.secs, e.st);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    {restart_i, extra_turn_i, end_turn_i, start_pause_i, freeze_i} = v.inp;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    {restart_i, extra_turn_i, end_turn_i, start_pause_i, freeze_i} = NO;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // Run to expiry and stay expired.
    for (int j = 1; j <= 40; j++) tbl.push_back(run_exp(j, "countdown"));
    tbl.push_back(mk(RS, 0, 0, 0, 3, S_RUN, "restart_from_expired"));
    for (int j = 1; j <= 12; j++) tbl.push_back(run_exp(j, "recount"));
    // Pause entered at secs=2, strobes ignored in PAUSE/PAUSE_DONE, end_turn resumes.
    tbl.push_back(mk(RS, 0, 0, 0, 3, S_RUN, "restart2"));
    for (int j = 1; j <= 4; j++) tbl.push_back(run_exp(j, "pre_pause"));
    tbl.push_back(mk(SP, 0, 0, 1, 2, S_PAU, "pause_entry"));
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk((k == 2 || k == 9) ? SP : NO, 0, (k >= 8), 1, 2,
                       (k >= 8) ? S_PDN : S_PAU, "pausing"));
    tbl.push_back(mk(ET, 0, 0, 0, 3, S_RUN, "end_turn_resume"));
    // Reload plus start_pause on the cycle with prescaler at its last count.
    for (int j = 1; j <= 11; j++) tbl.push_back(run_exp(j, "pre_coincide"));
    tbl.push_back(mk(EX | SP, 0, 0, 0, 3, S_RUN, "extra_beats_pause"));
    for (int j = 1; j <= 3; j++) tbl.push_back(run_exp(j, "no_pause_taken"));
    // Freeze during a pause; everything afterwards ignored.
    tbl.push_back(mk(SP, 0, 0, 1, 3, S_PAU, "pause_entry2"));
    for (int k = 1; k <= 2; k++) tbl.push_back(mk(NO, 0, 0, 1, 3, S_PAU, "pausing2"));
    tbl.push_back(mk(FZ, 0, 0, 0, 3, S_FRZ, "freeze_in_pause"));
    for (int i = 1; i <= 12; i++)
      tbl.push_back(mk((i == 5) ? RS : (i == 6) ? EX : (i == 7) ? SP : NO,
                       0, 0, 0, 3, S_FRZ, "frozen"));

    repeat (2) @(posedge clk);
    #1;
    sbq.push_back(mk(NO, 0, 0, 0, 3, S_RUN, "reset_state"));
    check_out();
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Asynchronous reset from FROZEN, sampled before any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sbq.push_back(mk(NO, 0, 0, 0, 3, S_RUN, "async_reset"));
    check_out();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reload on the cycle of the final tick: time_up must not rise.
    for (int j = 1; j <= TURN_CYC - 1; j++) step(run_exp(j, "pre_final_tick"));
    step(mk(RS, 0, 0, 0, 3, S_RUN, "reload_on_final_tick"));
    for (int j = 1; j <= TURN_CYC; j++) step(run_exp(j, "post_final_tick"));

    // Freeze while expired forces time_up low and holds secs at 0.
    step(mk(FZ, 0, 0, 0, 0, S_FRZ, "freeze_expired"));
    v = mk(NO, 0, 0, 0, 0, S_FRZ, "frozen_expired");
    repeat (6) step(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/turn_timer.md
Name: turn_timer

Overview:
- Per-turn countdown and mismatch-pause timer for the memory-card game.
- Sits directly upstream of the game control FSM and supplies its time_up_i and pause_done_i inputs.
- Consumes the FSM's restart_timer_o, start_pause_o, end_turn_o and extra_turn_o strobes, plus the datapath's game-over flag.
- Exports remaining seconds for the 7-segment display.

Parameters:
- CLK_HZ, 50_000_000, clock cycles per one-second tick (must be >= 2).
- TURN_SECS, 15, turn length in seconds (must be >= 1).
- PAUSE_SECS, 2, mismatch reveal pause in seconds (must be >= 1).
- WARN_SECS, 5, warning threshold; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- restart_i  in  1  reload turn countdown (FSM restart_timer_o).
- extra_turn_i  in  1  reload turn countdown (FSM extra_turn_o).
- end_turn_i  in  1  reload turn countdown and leave pause (FSM end_turn_o).
- start_pause_i  in  1  begin mismatch pause (FSM start_pause_o).
- freeze_i  in  1  game over; freeze the timer until reset.
- time_up_o  out  1  level: turn time expired.
- pause_done_o  out  1  level: pause elapsed.
- pause_active_o  out  1  high in PAUSE or PAUSE_DONE.
- secs_left_o  out  SW  remaining turn seconds; SW = $clog2(TURN_SECS+1).
- warn_o  out  1  low-time warning; tied 0 when the optional feature is off.
- state_o  out  3  encoded state, for debug.

Behaviour:
- Clocking and reset: single clock, asynchronous active-low reset.
- Reset values: state=RUN, secs_left_o=TURN_SECS, prescaler=0, time_up_o=0, pause_done_o=0, pause_active_o=0, warn_o=0.
- Tick generation: the prescaler counts 0..CLK_HZ-1 and emits a one-cycle tick when it reaches CLK_HZ-1, then wraps to 0.
- The prescaler clears on every reload and on every PAUSE entry.
- All outputs are registered.
- State RUN: on tick, secs decrements by 1.
  - At the edge where secs becomes 0, go to EXPIRED and set time_up_o=1.
  - So time_up_o rises exactly TURN_SECS*CLK_HZ cycles after a reload.
- State EXPIRED: time_up_o stays high and secs_left_o stays 0 until a reload or a pause; no wrap-around.
- State PAUSE: loads pause count = PAUSE_SECS; time_up_o=0; secs_left_o holds its value.
  - On each tick, decrement the pause count.
  - At the edge where it reaches 0, go to PAUSE_DONE with pause_done_o=1.
- State PAUSE_DONE: pause_done_o held high until end_turn_i or restart_i.
  - On that strobe, go to RUN with reload; pause_done_o drops the same edge.
- State FROZEN: entered from any state on freeze_i.
  - All counters stop; secs_left_o holds; time_up_o, pause_done_o and warn_o are forced 0.
  - Exits only on rst_n.
- Reload: any of restart_i, extra_turn_i, end_turn_i. Effect: go to RUN, secs=TURN_SECS, prescaler=0, time_up_o=0.
- Priority when events coincide in one cycle: freeze_i > reload > start_pause_i > tick.
  - Reload together with start_pause_i: reload wins.
  - Reload coinciding with the final tick: reload wins; time_up_o stays 0.
- start_pause_i is honoured only in RUN or EXPIRED; it is ignored in PAUSE, PAUSE_DONE and FROZEN.
- A reload in PAUSE, before the pause elapses, aborts the pause and goes to RUN.
- Reset mid-operation restores all reset values immediately.

Optional Feature:
- Macro: TURN_TIMER_WARN_EN.
- Defined: warn_o is registered and high while state=RUN and 0 < secs_left_o <= WARN_SECS.
- Defined: warn_o toggles at each half-second boundary, i.e. prescaler = CLK_HZ/2-1 or CLK_HZ-1, giving a blink; it starts high on entering the window.
- Not defined: warn_o is constant 0 and no half-second compare logic is built.

Decomposition:
- Package memgame_pkg:
  - timer_state_t enum: RUN=0, EXPIRED=1, PAUSE=2, PAUSE_DONE=3, FROZEN=4.
  - Default constants for TURN_SECS and PAUSE_SECS.
- Sub-module tick_gen: prescaler with inputs clk, rst_n, clr_i and output tick_o; parameter CLK_HZ.
  - The warn half-tick output is only present under the macro.

Test Plan (CLK_HZ=4, TURN_SECS=3, PAUSE_SECS=2, WARN_SECS=2):
- Release reset, no strobes -> secs_left_o goes 3,2,1,0 at cycles 4,8,12; time_up_o rises at cycle 12 and stays high through cycle 40.
- EXPIRED, then pulse restart_i -> next edge: time_up_o=0, secs_left_o=3; time_up_o rises again 12 cycles later.
- At secs=2, pulse start_pause_i -> pause_active_o=1, time_up_o=0; pause_done_o rises 8 cycles later and holds; pulse end_turn_i -> RUN with secs_left_o=3, pause_done_o=0.
- At prescaler=3 with secs=1, pulse extra_turn_i and start_pause_i together -> RUN, secs_left_o=3, time_up_o=0, no pause entered.
- In PAUSE after 3 cycles, assert freeze_i -> state_o=FROZEN, pause_done_o never rises; restart_i is ignored; rst_n low -> RUN, secs=3.
- With TURN_TIMER_WARN_EN, TURN_SECS=3 -> warn_o=0 while secs=3; warn_o toggles every 2 cycles while secs is 2 or 1; warn_o=0 at secs=0.
